muldiv_seq: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit that sits beside the execute-stage ALU.
- Takes operands after the ALU forwarding muxes (data1/data2), so results stay correct under forwarding.
- Runs one radix-2 step per cycle and asserts a stall to the pipeline controller until the result is ready.
- Owns the start/busy/done sequencing so the decode and hazard logic only see a single stall line.

---
 rtl/muldiv_seq.sv | 133 +++++++++++++
 tb/tb_muldiv_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit: one radix-2 step per cycle beside the execute ALU.
// Shift-add multiply (LSB first) and restoring divide (MSB first), with a single stall line.
`timescale 1ns/1ps
module muldiv_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         op_q, op_d;
    // d_q: multiplicand for MUL, divisor for DIV; mq_q: multiplier for MUL, dividend/quotient for DIV
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_quo;

    assign accept = start & ~flush & ((state_q == StIdle) | (state_q == StDone));
    assign last   = (count_q == CNT_W'(WIDTH - 1));

    // Datapath for one iteration step
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mq_q[0] ? d_q : {WIDTH{1'b0}})};
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        {div_borrow, div_diff} = {1'b0, div_shift} - {2'b00, d_q};
        if (div_borrow) begin
            div_rem = div_shift;
            div_quo = {mq_q[WIDTH-2:0], 1'b0};
        end else begin
            div_rem = div_diff;
            div_quo = {mq_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        d_d      = d_q;
        mq_d     = mq_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StBusy;
                        count_d = '0;
                        op_d    = op;
                        d_d     = op[1] ? opb : opa;
                        mq_d    = op[1] ? opa : opb;
                        acc_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StBusy: begin
                    count_d = count_q + CNT_W'(1);
                    if (op_q[1]) begin
                        acc_d = {{(WIDTH-1){1'b0}}, div_rem};
                        mq_d  = div_quo;
                    end else begin
                        acc_d = mul_acc;
                        mq_d  = mq_q >> 1;
                    end
                    if (last) begin
                        state_d = StDone;
                        case (op_q)
                            2'b00:   result_d = mul_acc[WIDTH-1:0];
                            2'b01:   result_d = mul_acc[2*WIDTH-1:WIDTH];
                            2'b10:   result_d = div_quo;
                            default: result_d = div_rem[WIDTH-1:0];
                        endcase
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= '0;
            d_q      <= '0;
            mq_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            d_q      <= d_d;
            mq_q     <= mq_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StBusy);
    assign done   = (state_q == StDone);
    assign stall  = accept | busy;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the unit idle; leaves it idle the same way.
    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        int   n;
        logic stall_low;
        logic busy_low;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        #1;
        check({name, " stall at start"}, stall, 1);
        @(posedge clk); #1;
        // Operands change after accept and must not matter
        start = 1'b0;
        opa   = ~a;
        opb   = ~b;
        op    = ~o;
        n         = 1;
        stall_low = 1'b0;
        busy_low  = 1'b0;
        while (!done && n < 40) begin
            if (!stall) stall_low = 1'b1;
            if (!busy) busy_low = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({name, " done cycle"}, n, 17);
        check({name, " stall/busy gap"}, {stall_low, busy_low}, 0);
        check({name, " stall in done"}, stall, 0);
        check({name, " result"}, result, exp);
        @(posedge clk); #1;
        check({name, " done width"}, done, 0);
    endtask

    initial begin
        int   n;
        logic seen;

        vecs[0] = '{"mul lo 1234x0100", 2'b00, 16'h1234, 16'h0100, 16'h3400};
        vecs[1] = '{"mul hi 1234x0100", 2'b01, 16'h1234, 16'h0100, 16'h0012};
        vecs[2] = '{"mul hi ffffxffff", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE};
        vecs[3] = '{"mul lo ffffxffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[4] = '{"div quo 1000/7",   2'b10, 16'd1000, 16'd7,    16'd142};
        vecs[5] = '{"div rem 1000/7",   2'b11, 16'd1000, 16'd7,    16'd6};
        vecs[6] = '{"div quo ab/0",     2'b10, 16'h00AB, 16'h0000, 16'hFFFF};
        vecs[7] = '{"div rem ab/0",     2'b11, 16'h00AB, 16'h0000, 16'h00AB};
        vecs[8] = '{"mul lo 3x5",       2'b00, 16'd3,    16'd5,    16'd15};
        vecs[9] = '{"div rem 100/3",    2'b11, 16'd100,  16'd3,    16'd1};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        #12;
        check("reset stall", stall, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back: start held through BUSY (ignored) and DONE (accepted)
        start = 1'b1;
        op    = 2'b10;
        opa   = 16'd1000;
        opb   = 16'd7;
        @(posedge clk); #1;
        opa = 16'd9;
        opb = 16'd2;
        n   = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b first done cycle", n, 17);
        check("b2b first result", result, 142);
        check("b2b stall in done with start", stall, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b second accepted", busy, 1);
        check("b2b result held", result, 142);
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b second done cycle", n, 17);
        check("b2b second result", result, 4);
        @(posedge clk); #1;

        // Flush in cycle 5 of DIV 100/3
        start = 1'b1;
        op    = 2'b10;
        opa   = 16'd100;
        opb   = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush stall while busy", stall, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy cleared", busy, 0);
        check("flush stall cleared", stall, 0);
        seen = 1'b0;
        repeat (25) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush no done", seen, 0);
        check("flush result kept", result, 4);

        // start and flush together in IDLE
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("start+flush stall", stall, 0);
        @(posedge clk); #1;
        check("start+flush not accepted", busy, 0);
        start = 1'b0;
        flush = 1'b0;

        // Reset in cycle 8 of MUL 3x5
        start = 1'b1;
        op    = 2'b00;
        opa   = 16'd3;
        opb   = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid reset stall", stall, 0);
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("post reset idle", seen, 0);
        run_op("mul after reset", 2'b00, 16'd3, 16'd5, 16'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
